// File: rtl/apb_i2c_cmd_sequencer.sv
// APB master turning one valid/ready command into one APB transfer to the I2C bridge.
// RX pops wait for the bridge RX FIFO to be non-empty; every ACCESS phase is bounded by a PREADY timeout.
module apb_i2c_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [1:0]  CMD_OP,
    input  logic [31:0] CMD_WDATA,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic        RSP_TIMEOUT,
    output logic [7:0]  ERR_COUNT,
    output logic        PSELx,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    input  logic        INT_RX,
    input  logic        INT_TX
);

    typedef enum logic [2:0] {IDLE, WAIT_RX, SETUP, ACCESS, RESP} state_t;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] OP_POP = 2'b11;

    state_t         state_reg;
    logic [CW-1:0]  wait_cnt_reg;
    logic [1:0]     op_reg;
    logic [31:0]    wdata_reg;
    logic [31:0]    paddr_reg;
    logic [31:0]    pwdata_reg;
    logic           pwrite_reg;
    logic [31:0]    rsp_rdata_reg;
    logic           rsp_err_reg;
    logic           rsp_timeout_reg;
    logic [7:0]     err_count_reg;

    logic [1:0]     sel_op;
    logic [31:0]    sel_wdata;
    logic [31:0]    sel_addr;

    // TX-empty is reported by the bridge but never gates a transfer.
    logic unused_int_tx;
    assign unused_int_tx = INT_TX;

    // SETUP can be entered straight from IDLE (fresh command) or from WAIT_RX (latched command).
    always_comb begin
        sel_op    = (state_reg == IDLE) ? CMD_OP : op_reg;
        sel_wdata = (state_reg == IDLE) ? CMD_WDATA : wdata_reg;
        sel_addr  = 32'd0;
        case (sel_op)
            2'b00:   sel_addr = 32'd8;
            2'b01:   sel_addr = 32'd12;
            2'b10:   sel_addr = 32'd2;
            default: sel_addr = 32'd4;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg       <= IDLE;
            wait_cnt_reg    <= '0;
            op_reg          <= 2'b00;
            wdata_reg       <= 32'd0;
            paddr_reg       <= 32'd0;
            pwdata_reg      <= 32'd0;
            pwrite_reg      <= 1'b0;
            rsp_rdata_reg   <= 32'd0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            err_count_reg   <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (CMD_VALID) begin
                        op_reg    <= CMD_OP;
                        wdata_reg <= CMD_WDATA;
                        if (CMD_OP == OP_POP && INT_RX) begin
                            state_reg <= WAIT_RX;
                        end else begin
                            paddr_reg  <= sel_addr;
                            pwrite_reg <= (sel_op != OP_POP);
                            if (sel_op != OP_POP) pwdata_reg <= sel_wdata;
                            state_reg  <= SETUP;
                        end
                    end
                end
                WAIT_RX: begin
                    if (!INT_RX) begin
                        paddr_reg  <= sel_addr;
                        pwrite_reg <= (sel_op != OP_POP);
                        if (sel_op != OP_POP) pwdata_reg <= sel_wdata;
                        state_reg  <= SETUP;
                    end
                end
                SETUP: begin
                    wait_cnt_reg <= '0;
                    state_reg    <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata_reg   <= pwrite_reg ? 32'd0 : PRDATA;
                        rsp_err_reg     <= PSLVERR;
                        rsp_timeout_reg <= 1'b0;
                        state_reg       <= RESP;
                    end else if (wait_cnt_reg == CNT_LAST) begin
                        rsp_rdata_reg   <= 32'd0;
                        rsp_err_reg     <= 1'b1;
                        rsp_timeout_reg <= 1'b1;
                        state_reg       <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_err_reg && err_count_reg != 8'hFF)
                        err_count_reg <= err_count_reg + 8'd1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // APB strobes decode the state register so reset drops them without waiting for a clock.
    assign PSELx       = (state_reg == SETUP) || (state_reg == ACCESS);
    assign PENABLE     = (state_reg == ACCESS);
    assign PWRITE      = pwrite_reg;
    assign PADDR       = paddr_reg;
    assign PWDATA      = pwdata_reg;
    assign CMD_READY   = (state_reg == IDLE) && !PRESET;
    assign RSP_VALID   = (state_reg == RESP);
    assign RSP_RDATA   = rsp_rdata_reg;
    assign RSP_ERR     = rsp_err_reg;
    assign RSP_TIMEOUT = rsp_timeout_reg;
    assign ERR_COUNT   = err_count_reg;

endmodule

// File: tb/tb_apb_i2c_cmd_sequencer.sv
// Directed bench for apb_i2c_cmd_sequencer: the bench plays the APB slave and checks latency and responses.
module tb_apb_i2c_cmd_sequencer;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [1:0]  CMD_OP = 2'b00;
    logic [31:0] CMD_WDATA = 32'd0;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic        RSP_TIMEOUT;
    logic [7:0]  ERR_COUNT;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = 32'hDEAD_BEEF;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;
    logic        INT_RX = 1'b0;
    logic        INT_TX = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    // Results of the last exec_cmd call
    int          lat, acc, sel_k;
    logic        got_rsp;
    logic [31:0] s_addr, s_wdata, r_rdata;
    logic        s_write, r_err, r_tmo;

    apb_i2c_cmd_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
        .ERR_COUNT(ERR_COUNT),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .INT_RX(INT_RX), .INT_TX(INT_TX)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    // Issue one command and play the slave; ends on the negedge where RSP_VALID is seen.
    // lat counts negedges after the handshake edge; PREADY rises on ACCESS cycle ready_at (0 = never).
    task automatic exec_cmd(input logic [1:0] op, input logic [31:0] wdata, input int rx_wait,
                            input int ready_at, input logic slverr);
        int guard;
        int k;
        INT_RX    = (rx_wait > 0);
        CMD_OP    = op;
        CMD_WDATA = wdata;
        CMD_VALID = 1'b1;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        guard = 0;
        while (!CMD_READY && guard < 20) begin
            tick();
            guard++;
        end
        if (guard == 20) check("cmd_ready_wait", 32'(CMD_READY), 32'd1);
        tick();
        CMD_VALID = 1'b0;
        k = 1; acc = 0; sel_k = 0; got_rsp = 1'b0;
        while (k <= 60) begin
            if (PSELx && sel_k == 0) begin
                sel_k   = k;
                s_addr  = PADDR;
                s_wdata = PWDATA;
                s_write = PWRITE;
            end
            if (RSP_VALID) begin
                got_rsp = 1'b1;
                r_rdata = RSP_RDATA;
                r_err   = RSP_ERR;
                r_tmo   = RSP_TIMEOUT;
                break;
            end
            if (PENABLE) begin
                acc++;
                PREADY  = (acc == ready_at);
                PSLVERR = slverr;
            end
            INT_RX = (k < rx_wait);
            tick();
            k++;
        end
        lat = k;
        PREADY = 1'b0;
        PSLVERR = 1'b0;
        check("rsp_seen", 32'(got_rsp), 32'd1);
        $display("[TB] op=%0d wdata=0x%0h lat=%0d access=%0d rdata=0x%0h err=%0d tmo=%0d",
                 op, wdata, lat, acc, r_rdata, r_err, r_tmo);
    endtask

    initial begin
        logic saw_rsp;
        // Reset held with a pending command
        CMD_VALID = 1'b1;
        repeat (3) @(negedge PCLK);
        check("rst_cmd_ready", 32'(CMD_READY), 32'd0);
        check("rst_psel",      32'(PSELx | PENABLE), 32'd0);
        check("rst_paddr",     PADDR, 32'd0);
        check("rst_pwdata",    PWDATA, 32'd0);
        check("rst_err_count", 32'(ERR_COUNT), 32'd0);
        check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        PRESET = 1'b0;
        #1;
        check("post_rst_ready", 32'(CMD_READY), 32'd1);

        // op 00, zero-wait slave
        exec_cmd(2'b00, 32'h0000_1A2B, 0, 1, 1'b0);
        check("cfg_setup_k",  32'(sel_k), 32'd1);
        check("cfg_paddr",    s_addr, 32'd8);
        check("cfg_pwrite",   32'(s_write), 32'd1);
        check("cfg_pwdata",   s_wdata, 32'h0000_1A2B);
        check("cfg_access",   32'(acc), 32'd1);
        check("cfg_latency",  32'(lat), 32'd3);
        check("cfg_err",      32'(r_err), 32'd0);
        check("cfg_rdata",    r_rdata, 32'd0);
        tick();
        check("cfg_ready_back", 32'(CMD_READY), 32'd1);
        check("cfg_rsp_drop",   32'(RSP_VALID), 32'd0);

        // op 11 with RX empty for 5 cycles
        exec_cmd(2'b11, 32'h1234_5678, 5, 1, 1'b0);
        check("rx_first_sel", 32'(sel_k), 32'd6);
        check("rx_paddr",     s_addr, 32'd4);
        check("rx_pwrite",    32'(s_write), 32'd0);
        check("rx_latency",   32'(lat), 32'd8);
        check("rx_rdata",     r_rdata, 32'hDEAD_BEEF);
        check("rx_err",       32'(r_err), 32'd0);
        tick();

        // op 10, PREADY never comes
        exec_cmd(2'b10, 32'h0000_00A5, 0, 0, 1'b0);
        check("tmo_paddr",   s_addr, 32'd2);
        check("tmo_access",  32'(acc), 32'd16);
        check("tmo_flag",    32'(r_tmo), 32'd1);
        check("tmo_err",     32'(r_err), 32'd1);
        check("tmo_rdata",   r_rdata, 32'd0);
        tick();
        check("tmo_err_count", 32'(ERR_COUNT), 32'd1);

        // PREADY arrives on the last allowed ACCESS cycle
        exec_cmd(2'b10, 32'h0000_005A, 0, 16, 1'b0);
        check("edge_access", 32'(acc), 32'd16);
        check("edge_tmo",    32'(r_tmo), 32'd0);
        check("edge_err",    32'(r_err), 32'd0);
        tick();
        check("edge_err_count", 32'(ERR_COUNT), 32'd1);

        // op 01 with PSLVERR, then saturate the error counter
        exec_cmd(2'b01, 32'h0000_0100, 0, 1, 1'b1);
        check("slv_paddr", s_addr, 32'd12);
        check("slv_err",   32'(r_err), 32'd1);
        check("slv_tmo",   32'(r_tmo), 32'd0);
        tick();
        check("slv_err_count", 32'(ERR_COUNT), 32'd2);
        for (int i = 1; i < 300; i++) begin
            exec_cmd(2'b01, 32'(i), 0, 1, 1'b1);
            tick();
        end
        check("sat_err_count", 32'(ERR_COUNT), 32'd255);

        // Reset asserted during ACCESS
        CMD_OP = 2'b00; CMD_WDATA = 32'h5; CMD_VALID = 1'b1; PREADY = 1'b0;
        tick();
        CMD_VALID = 1'b0;
        tick();
        check("mid_in_access", 32'(PENABLE), 32'd1);
        #2 PRESET = 1'b1;
        #1;
        check("mid_psel_drop",  32'(PSELx | PENABLE), 32'd0);
        check("mid_ready_low",  32'(CMD_READY), 32'd0);
        check("mid_err_count",  32'(ERR_COUNT), 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;
        PREADY = 1'b1;
        saw_rsp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 if (RSP_VALID) saw_rsp = 1'b1;
            tick();
        end
        PREADY = 1'b0;
        check("mid_no_rsp",    32'(saw_rsp), 32'd0);
        check("mid_ready_back", 32'(CMD_READY), 32'd1);

        exec_cmd(2'b01, 32'h0000_0042, 0, 1, 1'b0);
        check("recover_latency", 32'(lat), 32'd3);
        check("recover_paddr",   s_addr, 32'd12);
        check("recover_err",     32'(r_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_i2c_cmd_sequencer.md
# apb_i2c_cmd_sequencer

APB master that sequences single-word command requests onto the APB slave port of the APB-to-I2C bridge. Requests arrive on a valid/ready command port and are turned into exactly one APB transfer each. The block maps each command to the bridge register map (config, timeout, TX push, RX pop), gates RX pops on the bridge's RX-empty interrupt, and bounds every transfer with a PREADY timeout. It returns one response per command and keeps a saturating error count.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum ACCESS-phase cycles waiting for PREADY; legal range ≥1.

Ports:
- PCLK  in  1  clock, rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  sequencer can accept a command.
- CMD_OP  in  2  00 = write CONFIG, 01 = write TIMEOUT, 10 = push TX, 11 = pop RX.
- CMD_WDATA  in  32  write data; ignored for op 11.
- RSP_VALID  out  1  one-cycle response strobe.
- RSP_RDATA  out  32  read data for op 11; 0 otherwise.
- RSP_ERR  out  1  PSLVERR seen or timeout.
- RSP_TIMEOUT  out  1  transfer ended by timeout.
- ERR_COUNT  out  8  saturating count of responses with RSP_ERR=1.
- PSELx, PENABLE, PWRITE  out  1 each  APB master control.
- PADDR  out  32  APB address.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.
- INT_RX  in  1  bridge RX FIFO empty (1 = empty).
- INT_TX  in  1  bridge TX FIFO empty; status only, not used for gating.

## Operation
- Address map:
  - op 00 → PADDR=8, write.
  - op 01 → PADDR=12, write.
  - op 10 → PADDR=2, write.
  - op 11 → PADDR=4, read.
- FSM states: IDLE, WAIT_RX, SETUP, ACCESS, RESP.
- IDLE: CMD_READY=1. On CMD_VALID=1, latch op and data, then:
  - op=11 and INT_RX=1 → WAIT_RX.
  - otherwise → SETUP.
- WAIT_RX: hold until INT_RX=0, then → SETUP. There is no timeout in this state.
- SETUP: PSELx=1, PENABLE=0. PADDR, PWRITE and PWDATA are valid here and stable until the end of ACCESS. Always → ACCESS.
- ACCESS: PSELx=1, PENABLE=1. The wait counter starts at 0 on entry and increments each cycle PREADY=0.
  - PREADY=1: capture PRDATA (reads only) and PSLVERR, then → RESP.
  - PREADY=0 with counter = TIMEOUT_CYCLES-1: set timeout flag, RSP_RDATA=0, then → RESP.
- RESP: RSP_VALID=1 for exactly one cycle, RSP_* held from capture, then → IDLE.
- RSP_ERR = captured PSLVERR | timeout flag. PSLVERR is ignored unless PREADY=1.
- ERR_COUNT increments on each RSP_VALID with RSP_ERR=1 and saturates at 255.
- Register ownership:
  - PSELx, PENABLE, PWRITE, PADDR, PWDATA, RSP_* and ERR_COUNT come from registers or are decoded from the state register; no combinational path from inputs.
  - CMD_READY = (state==IDLE) & ~PRESET.
- In all states except SETUP and ACCESS, PSELx=PENABLE=0 and PADDR/PWDATA/PWRITE hold their last value.

## Timing
- Reset (async assert): state=IDLE. All outputs go to 0, including CMD_READY, ERR_COUNT, PADDR and PWDATA.
- Reset mid-transfer: the APB transfer is abandoned immediately (PSELx/PENABLE drop asynchronously), the latched command is discarded, and no response is issued.
- First command can be accepted on the first rising edge after PRESET deasserts.
- Latency with zero-wait slave, handshake at edge E0:
  - SETUP after E0.
  - ACCESS after E1.
  - PREADY sampled at E2; RSP_VALID=1 after E2.
  - IDLE/CMD_READY=1 after E3.
  - Next handshake at E4 at the earliest, so peak throughput is one command per 4 cycles.
- Each PREADY=0 cycle in ACCESS adds 1 cycle.
- Timeout: ACCESS lasts exactly TIMEOUT_CYCLES cycles when PREADY stays 0.
- PREADY=1 in the same cycle the counter reaches TIMEOUT_CYCLES-1: PREADY wins, no timeout.
- WAIT_RX adds one cycle per cycle INT_RX=1. SETUP begins the cycle after INT_RX is sampled 0.
- CMD_VALID outside IDLE is ignored (CMD_READY=0). The requester holds the command until handshake.

## Test plan
- Reset with CMD_VALID=1 → all outputs 0, no APB activity. After release: CMD_READY=1 and the command is accepted on the next edge.
- op 00, CMD_WDATA=0x0000_1A2B, zero-wait slave:
  - SETUP: PADDR=8, PWRITE=1, PWDATA=0x1A2B, PENABLE=0.
  - ACCESS: PENABLE=1.
  - RSP_VALID 3 cycles after handshake, RSP_ERR=0.
- op 11 with INT_RX=1 for 5 cycles, then 0; PRDATA=0xDEAD_BEEF:
  - No PSELx during the wait.
  - Read to PADDR=4 follows.
  - RSP_RDATA=0xDEADBEEF.
- op 10 with PREADY held 0, TIMEOUT_CYCLES=16:
  - ACCESS lasts 16 cycles.
  - RSP_TIMEOUT=1, RSP_ERR=1, RSP_RDATA=0, ERR_COUNT=1.
- op 01 with PREADY=1 and PSLVERR=1 → RSP_ERR=1, RSP_TIMEOUT=0. After 300 such commands, ERR_COUNT=255.
- PRESET asserted during ACCESS → PSELx/PENABLE 0 the same cycle, no RSP_VALID, CMD_READY=1 after release.
